// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: NREQ producers share one async-FIFO write port in bursts of up to BURST_LEN words.
// Latency: request seen in IDLE at cycle N -> grant at N+1, first write at N+1; one bubble cycle between grants.
// Backpressure: wfull combinationally masks ack/winc; the owner stalls, holding state and beat count, until space frees.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic                  wfull,
  output logic [NREQ-1:0]       ack,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]       state;
  logic [OW-1:0]    last;
  logic [7:0]       cnt;
  logic [DSIZE-1:0] slice [NREQ];
  logic [OW-1:0]    pick;
  logic             pick_vld;
  logic [OW:0]      idx;
  logic             own_req;
  logic             last_beat;

  // Unpack the flat producer data bus into one word per producer.
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = req_data[g*DSIZE +: DSIZE];
  end

  assign busy      = (state == S_BURST);
  assign own_req   = req[owner];
  assign wdata     = slice[owner];
  assign winc      = |ack;
  assign last_beat = (cnt == 8'(BURST_LEN - 1));

  // Only the owner can be acked, and never while the FIFO reports full.
  always_comb begin
    ack = '0;
    if (busy && own_req && !wfull) begin
      ack[owner] = 1'b1;
    end
  end

  // Round-robin search: first requester starting just after the previous owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = {1'b0, last} + (OW+1)'(i);
      if (idx >= (OW+1)'(NREQ)) begin
        idx = idx - (OW+1)'(NREQ);
      end
      if (!pick_vld && req[idx[OW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[OW-1:0];
      end
    end
  end

  // Grant / burst state machine; a full FIFO stalls the burst without revoking ownership.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= S_IDLE;
      owner <= '0;
      last  <= OW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            owner <= pick;
            last  <= pick;
            cnt   <= '0;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!own_req) begin
            state <= S_IDLE;
          end else if (winc) begin
            cnt <= cnt + 8'd1;
            if (last_beat) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
